ex_pipeline_regs: RTL and testbench

- Pipeline register bank between decode and memory stages of the 5-stage 64-bit ARM-subset CPU.
- Holds the ID/EX register, the EX/MEM register and the 4-bit condition-flag register (enabled D flip-flops).
- Decode-stage values enter once per clock. EX-stage copies drive the ALU-source mux and ALU. MEM-stage copies drive data memory and write-back select. Flags feed branch control.

---
 rtl/ex_pipeline_regs_if.sv | 63 ++++++
 rtl/ex_pipeline_regs.sv | 107 ++++++++++
 tb/tb_ex_pipeline_regs.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ex_pipeline_regs_if.sv
// Bundle of the ID-side inputs and the EX/MEM-side outputs of the pipeline register bank.
// master: the pipeline around the bank (decode, ALU, memory).
// slave: the register bank itself.
interface ex_pipeline_regs_if #(
  parameter int WIDTH   = 64,
  parameter int RADDR_W = 5
);
  logic               RegWrite_ID;
  logic               MemWrite_ID;
  logic [2:0]         ALUOp_ID;
  logic [1:0]         ALUSrc_ID;
  logic               MemToReg_ID;
  logic               flagWrite_ID;
  logic [WIDTH-1:0]   Imm12Ext_ID;
  logic [WIDTH-1:0]   Daddr9Ext_ID;
  logic [WIDTH-1:0]   LS_ID;
  logic [RADDR_W-1:0] Rd_ID;
  logic [WIDTH-1:0]   Da_ID;
  logic [WIDTH-1:0]   Db_ID;
  logic [WIDTH-1:0]   ALUResult_EX;
  logic [3:0]         aluFlags_EX;

  logic               RegWrite_EX;
  logic               MemWrite_EX;
  logic               MemToReg_EX;
  logic               flagWrite_EX;
  logic [2:0]         ALUOp_EX;
  logic [1:0]         ALUSrc_EX;
  logic [WIDTH-1:0]   Imm12Ext_EX;
  logic [WIDTH-1:0]   Daddr9Ext_EX;
  logic [WIDTH-1:0]   LS_EX;
  logic [WIDTH-1:0]   Da_EX;
  logic [WIDTH-1:0]   Db_EX;
  logic [RADDR_W-1:0] Rd_EX;

  logic               RegWrite_MEM;
  logic               MemWrite_MEM;
  logic               MemToReg_MEM;
  logic               flagWrite_MEM;
  logic [WIDTH-1:0]   Db_MEM;
  logic [WIDTH-1:0]   Daddr9Ext_MEM;
  logic [WIDTH-1:0]   ALUResult_MEM;
  logic [RADDR_W-1:0] Rd_MEM;
  logic [3:0]         flags;

  modport master (
    output RegWrite_ID, MemWrite_ID, ALUOp_ID, ALUSrc_ID, MemToReg_ID, flagWrite_ID,
           Imm12Ext_ID, Daddr9Ext_ID, LS_ID, Rd_ID, Da_ID, Db_ID, ALUResult_EX, aluFlags_EX,
    input  RegWrite_EX, MemWrite_EX, MemToReg_EX, flagWrite_EX, ALUOp_EX, ALUSrc_EX,
           Imm12Ext_EX, Daddr9Ext_EX, LS_EX, Da_EX, Db_EX, Rd_EX,
           RegWrite_MEM, MemWrite_MEM, MemToReg_MEM, flagWrite_MEM,
           Db_MEM, Daddr9Ext_MEM, ALUResult_MEM, Rd_MEM, flags
  );

  modport slave (
    input  RegWrite_ID, MemWrite_ID, ALUOp_ID, ALUSrc_ID, MemToReg_ID, flagWrite_ID,
           Imm12Ext_ID, Daddr9Ext_ID, LS_ID, Rd_ID, Da_ID, Db_ID, ALUResult_EX, aluFlags_EX,
    output RegWrite_EX, MemWrite_EX, MemToReg_EX, flagWrite_EX, ALUOp_EX, ALUSrc_EX,
           Imm12Ext_EX, Daddr9Ext_EX, LS_EX, Da_EX, Db_EX, Rd_EX,
           RegWrite_MEM, MemWrite_MEM, MemToReg_MEM, flagWrite_MEM,
           Db_MEM, Daddr9Ext_MEM, ALUResult_MEM, Rd_MEM, flags
  );
endinterface

// File: rtl/ex_pipeline_regs.sv
// ID/EX and EX/MEM pipeline registers plus the architectural condition-flag register.
// Pure register bank: every output comes straight from a flop, no stall or flush.
module ex_pipeline_regs #(
  parameter int WIDTH   = 64,
  parameter int RADDR_W = 5
) (
  input  logic clk,
  input  logic reset,
  ex_pipeline_regs_if.slave bus
);

  typedef struct packed {
    logic               reg_write;
    logic               mem_write;
    logic               mem_to_reg;
    logic               flag_write;
    logic [2:0]         alu_op;
    logic [1:0]         alu_src;
    logic [WIDTH-1:0]   imm12_ext;
    logic [WIDTH-1:0]   daddr9_ext;
    logic [WIDTH-1:0]   ls;
    logic [WIDTH-1:0]   da;
    logic [WIDTH-1:0]   db;
    logic [RADDR_W-1:0] rd;
  } id_ex_t;

  typedef struct packed {
    logic               reg_write;
    logic               mem_write;
    logic               mem_to_reg;
    logic               flag_write;
    logic [WIDTH-1:0]   db;
    logic [WIDTH-1:0]   daddr9_ext;
    logic [WIDTH-1:0]   alu_result;
    logic [RADDR_W-1:0] rd;
  } ex_mem_t;

  id_ex_t     id_ex_d,  id_ex_q;
  ex_mem_t    ex_mem_d, ex_mem_q;
  logic [3:0] flags_d,  flags_q;

  // Next-state: decode values enter EX, EX values advance to MEM, flags load when the EX instruction asks.
  always_comb begin
    id_ex_d.reg_write   = bus.RegWrite_ID;
    id_ex_d.mem_write   = bus.MemWrite_ID;
    id_ex_d.mem_to_reg  = bus.MemToReg_ID;
    id_ex_d.flag_write  = bus.flagWrite_ID;
    id_ex_d.alu_op      = bus.ALUOp_ID;
    id_ex_d.alu_src     = bus.ALUSrc_ID;
    id_ex_d.imm12_ext   = bus.Imm12Ext_ID;
    id_ex_d.daddr9_ext  = bus.Daddr9Ext_ID;
    id_ex_d.ls          = bus.LS_ID;
    id_ex_d.da          = bus.Da_ID;
    id_ex_d.db          = bus.Db_ID;
    id_ex_d.rd          = bus.Rd_ID;

    ex_mem_d.reg_write  = id_ex_q.reg_write;
    ex_mem_d.mem_write  = id_ex_q.mem_write;
    ex_mem_d.mem_to_reg = id_ex_q.mem_to_reg;
    ex_mem_d.flag_write = id_ex_q.flag_write;
    ex_mem_d.db         = id_ex_q.db;
    ex_mem_d.daddr9_ext = id_ex_q.daddr9_ext;
    ex_mem_d.alu_result = bus.ALUResult_EX;
    ex_mem_d.rd         = id_ex_q.rd;

    // Enable is the EX-stage copy, so flags commit as the instruction leaves EX.
    flags_d = flags_q;
    if (id_ex_q.flag_write) flags_d = bus.aluFlags_EX;
  end

  // State registers with asynchronous clear; in-flight instructions are dropped on reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      id_ex_q  <= '0;
      ex_mem_q <= '0;
      flags_q  <= '0;
    end else begin
      id_ex_q  <= id_ex_d;
      ex_mem_q <= ex_mem_d;
      flags_q  <= flags_d;
    end
  end

  assign bus.RegWrite_EX   = id_ex_q.reg_write;
  assign bus.MemWrite_EX   = id_ex_q.mem_write;
  assign bus.MemToReg_EX   = id_ex_q.mem_to_reg;
  assign bus.flagWrite_EX  = id_ex_q.flag_write;
  assign bus.ALUOp_EX      = id_ex_q.alu_op;
  assign bus.ALUSrc_EX     = id_ex_q.alu_src;
  assign bus.Imm12Ext_EX   = id_ex_q.imm12_ext;
  assign bus.Daddr9Ext_EX  = id_ex_q.daddr9_ext;
  assign bus.LS_EX         = id_ex_q.ls;
  assign bus.Da_EX         = id_ex_q.da;
  assign bus.Db_EX         = id_ex_q.db;
  assign bus.Rd_EX         = id_ex_q.rd;

  assign bus.RegWrite_MEM  = ex_mem_q.reg_write;
  assign bus.MemWrite_MEM  = ex_mem_q.mem_write;
  assign bus.MemToReg_MEM  = ex_mem_q.mem_to_reg;
  assign bus.flagWrite_MEM = ex_mem_q.flag_write;
  assign bus.Db_MEM        = ex_mem_q.db;
  assign bus.Daddr9Ext_MEM = ex_mem_q.daddr9_ext;
  assign bus.ALUResult_MEM = ex_mem_q.alu_result;
  assign bus.Rd_MEM        = ex_mem_q.rd;
  assign bus.flags         = flags_q;

endmodule

// File: tb/tb_ex_pipeline_regs.sv
// Scoreboard bench for ex_pipeline_regs: stimulus queues expected values per cycle,
// a negedge monitor pops and compares them.
module tb_ex_pipeline_regs;

  localparam int NSIG = 21;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  ex_pipeline_regs_if #(.WIDTH(64), .RADDR_W(5)) bus ();

  ex_pipeline_regs #(.WIDTH(64), .RADDR_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    int          id;
    logic [63:0] exp;
  } exp_t;

  exp_t sb[$];

  string names [NSIG] = '{"RegWrite_EX", "MemWrite_EX", "MemToReg_EX", "flagWrite_EX",
                          "ALUOp_EX", "ALUSrc_EX", "Imm12Ext_EX", "Daddr9Ext_EX", "LS_EX",
                          "Da_EX", "Db_EX", "Rd_EX", "RegWrite_MEM", "MemWrite_MEM",
                          "MemToReg_MEM", "flagWrite_MEM", "Db_MEM", "Daddr9Ext_MEM",
                          "ALUResult_MEM", "Rd_MEM", "flags"};
  int    wd    [NSIG] = '{1, 1, 1, 1, 3, 2, 64, 64, 64, 64, 64, 5, 1, 1, 1, 1, 64, 64, 64, 5, 4};

  function automatic logic [63:0] rd_sig(int id);
    case (id)
      0:  return 64'(bus.RegWrite_EX);
      1:  return 64'(bus.MemWrite_EX);
      2:  return 64'(bus.MemToReg_EX);
      3:  return 64'(bus.flagWrite_EX);
      4:  return 64'(bus.ALUOp_EX);
      5:  return 64'(bus.ALUSrc_EX);
      6:  return bus.Imm12Ext_EX;
      7:  return bus.Daddr9Ext_EX;
      8:  return bus.LS_EX;
      9:  return bus.Da_EX;
      10: return bus.Db_EX;
      11: return 64'(bus.Rd_EX);
      12: return 64'(bus.RegWrite_MEM);
      13: return 64'(bus.MemWrite_MEM);
      14: return 64'(bus.MemToReg_MEM);
      15: return 64'(bus.flagWrite_MEM);
      16: return bus.Db_MEM;
      17: return bus.Daddr9Ext_MEM;
      18: return bus.ALUResult_MEM;
      19: return 64'(bus.Rd_MEM);
      default: return 64'(bus.flags);
    endcase
  endfunction

  function automatic logic [63:0] ones(int w);
    logic [63:0] one;
    one = 64'd1;
    return (w >= 64) ? '1 : ((one << w) - 64'd1);
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic expect_at(int dc, int id, logic [63:0] v);
    exp_t e;
    e.cyc = cyc + dc;
    e.id  = id;
    e.exp = v;
    sb.push_back(e);
  endtask

  task automatic drive_all(logic [63:0] v);
    bus.RegWrite_ID  = v[0];
    bus.MemWrite_ID  = v[0];
    bus.MemToReg_ID  = v[0];
    bus.flagWrite_ID = v[0];
    bus.ALUOp_ID     = v[2:0];
    bus.ALUSrc_ID    = v[1:0];
    bus.Imm12Ext_ID  = v;
    bus.Daddr9Ext_ID = v;
    bus.LS_ID        = v;
    bus.Rd_ID        = v[4:0];
    bus.Da_ID        = v;
    bus.Db_ID        = v;
    bus.ALUResult_EX = v;
    bus.aluFlags_EX  = v[3:0];
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      errors++;
      checks++;
      $display("FAIL drain: %0d expectations still pending, required 0", sb.size());
      sb.delete();
    end
  endtask

  // Monitor: at each negedge compare every expectation due this cycle.
  initial begin
    forever begin
      @(negedge clk);
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].cyc < cyc) begin
          errors++;
          checks++;
          $display("FAIL stale_%s: due cycle %0d, now %0d", names[sb[i].id], sb[i].cyc, cyc);
          sb.delete(i);
        end else if (sb[i].cyc == cyc) begin
          chk(names[sb[i].id], rd_sig(sb[i].id), sb[i].exp);
          sb.delete(i);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0;
    drive_all('0);
    #1;
    for (int i = 0; i < NSIG; i++) chk({"init_", names[i]}, rd_sig(i), 64'd0);
    @(negedge clk);
    reset = 1'b1;

    // Fill the pipe with ones, then assert reset between edges.
    drive_all('1);
    @(posedge clk);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    for (int i = 0; i < NSIG; i++) chk({"rst_", names[i]}, rd_sig(i), 64'd0);

    // Release with inputs held at ones.
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 12; i++) expect_at(1, i, ones(wd[i]));
    expect_at(1, 18, '1);
    expect_at(1, 12, 64'd0);
    expect_at(1, 20, 64'd0);
    for (int i = 12; i < 20; i++) expect_at(2, i, ones(wd[i]));
    expect_at(2, 20, 64'hF);
    @(negedge clk);
    @(negedge clk);

    // Pipelining of operands.
    drive_all('0);
    bus.Da_ID = 64'h1111;
    bus.Db_ID = 64'h1111;
    expect_at(1, 9, 64'h1111);
    expect_at(1, 10, 64'h1111);
    expect_at(2, 16, 64'h1111);
    @(negedge clk);
    bus.Da_ID = 64'h2222;
    bus.Db_ID = 64'h2222;
    expect_at(1, 9, 64'h2222);
    expect_at(2, 16, 64'h2222);
    @(negedge clk);
    bus.Da_ID     = 64'h3333;
    bus.Db_ID     = 64'h3333;
    bus.ALUOp_ID  = 3'b110;
    bus.ALUSrc_ID = 2'b10;
    bus.Rd_ID     = 5'd31;
    expect_at(1, 9, 64'h3333);
    expect_at(1, 4, 64'h6);
    expect_at(1, 5, 64'h2);
    expect_at(1, 11, 64'd31);
    expect_at(2, 19, 64'd31);
    expect_at(2, 16, 64'h3333);
    @(negedge clk);

    // Flag enable: flag-writing instruction, then its ALU flags while in EX.
    drive_all('0);
    bus.flagWrite_ID = 1'b1;
    bus.aluFlags_EX  = 4'b1111;
    expect_at(1, 3, 64'd1);
    expect_at(1, 20, 64'd0);
    @(negedge clk);
    bus.flagWrite_ID = 1'b0;
    bus.aluFlags_EX  = 4'b0100;
    bus.ALUResult_EX = 64'hFFFF_FFFF_FFFF_FFF8;
    expect_at(1, 20, 64'h4);
    expect_at(1, 18, 64'hFFFF_FFFF_FFFF_FFF8);
    expect_at(1, 15, 64'd1);
    @(negedge clk);
    bus.aluFlags_EX  = 4'b1011;
    bus.ALUResult_EX = 64'd0;
    expect_at(1, 20, 64'h4);
    expect_at(2, 20, 64'h4);
    expect_at(1, 18, 64'd0);
    wait_drain();

    // Async reset with an instruction in flight.
    @(negedge clk);
    drive_all(64'hAAAA);
    bus.flagWrite_ID = 1'b1;
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    for (int i = 0; i < NSIG; i++) chk({"midrst_", names[i]}, rd_sig(i), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    drive_all('0);
    bus.Da_ID        = 64'h5555;
    bus.Rd_ID        = 5'd7;
    bus.flagWrite_ID = 1'b1;
    bus.aluFlags_EX  = 4'b1001;
    expect_at(1, 9, 64'h5555);
    expect_at(1, 11, 64'd7);
    expect_at(1, 20, 64'd0);
    expect_at(2, 19, 64'd7);
    expect_at(2, 20, 64'h9);
    @(negedge clk);
    bus.flagWrite_ID = 1'b0;
    wait_drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
